// File: rtl/btn_event_decoder.sv
// Turns a debounced button level into registered press/release/long-press/double-tap pulses plus a held flag.
// Define BTN_DBL_TAP_EN to build in the double-tap window (GAP state and second-tap flag).
module btn_event_decoder #(
  parameter int CNT_WIDTH  = 26,
  parameter int LONG_TICKS = 50_000_000,
  parameter int DBL_TICKS  = 25_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_db_i,
  output logic press_o,
  output logic release_o,
  output logic long_press_o,
  output logic double_tap_o,
  output logic held_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_LONG    = 2'd2;
  localparam logic [CNT_WIDTH-1:0] LONG_TERM = CNT_WIDTH'(LONG_TICKS - 1);

  if (LONG_TICKS < 2 || DBL_TICKS < 2) begin : g_bad_ticks
    $error("btn_event_decoder: LONG_TICKS and DBL_TICKS must be >= 2");
  end

`ifdef BTN_DBL_TAP_EN
  localparam logic [1:0] ST_GAP = 2'd3;
  localparam logic [CNT_WIDTH-1:0] DBL_TERM = CNT_WIDTH'(DBL_TICKS - 1);
  logic second_q, second_d;
  logic dbl_q, dbl_d;
`endif

  logic                 btn_q;
  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic                 long_q, long_d;
  logic                 held_q, held_d;
  logic                 rise, fall;

  assign rise = btn_db_i & ~btn_q;
  assign fall = ~btn_db_i & btn_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
`ifdef BTN_DBL_TAP_EN
    second_d  = second_q;
    dbl_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          cnt_d   = '0;
`ifdef BTN_DBL_TAP_EN
          second_d = 1'b0;
`endif
          state_d = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        // a release on the terminal cycle takes priority over the long press
        if (fall) begin
          release_d = 1'b1;
          cnt_d     = '0;
`ifdef BTN_DBL_TAP_EN
          state_d   = second_q ? ST_IDLE : ST_GAP;
`else
          state_d   = ST_IDLE;
`endif
        end else if (cnt_q == LONG_TERM) begin
          long_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_LONG;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LONG: begin
        if (fall) begin
          release_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end
      end
`ifdef BTN_DBL_TAP_EN
      ST_GAP: begin
        if (rise) begin
          press_d  = 1'b1;
          dbl_d    = 1'b1;
          second_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_PRESSED;
        end else if (cnt_q == DBL_TERM) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    held_d = (state_d == ST_LONG);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_q     <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
`ifdef BTN_DBL_TAP_EN
      second_q  <= 1'b0;
      dbl_q     <= 1'b0;
`endif
    end else begin
      btn_q     <= btn_db_i;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      held_q    <= held_d;
`ifdef BTN_DBL_TAP_EN
      second_q  <= second_d;
      dbl_q     <= dbl_d;
`endif
    end
  end

  assign press_o      = press_q;
  assign release_o    = release_q;
  assign long_press_o = long_q;
  assign held_o       = held_q;
`ifdef BTN_DBL_TAP_EN
  assign double_tap_o = dbl_q;
`else
  assign double_tap_o = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event_decoder.sv
// Scoreboard bench for btn_event_decoder (LONG_TICKS=8, DBL_TICKS=6); expectations follow BTN_DBL_TAP_EN.
module tb_btn_event_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic press, rel, lp, dt, held;
  logic async_chk = 1'b0;

  logic [4:0] exp_q[$];
  string      name_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;

  logic [4:0] m_exp, m_act;
  string      m_name;

  always #5 clk = ~clk;

  btn_event_decoder #(.CNT_WIDTH(4), .LONG_TICKS(8), .DBL_TICKS(6)) dut (
    .clk_i(clk), .rst_i(rst), .btn_db_i(btn),
    .press_o(press), .release_o(rel), .long_press_o(lp),
    .double_tap_o(dt), .held_o(held)
  );

  // {press, release, long_press, double_tap, held}
  function automatic logic [4:0] dec(input byte c);
    case (c)
      "P":     return 5'b10000;
      "R":     return 5'b01000;
      "L":     return 5'b00101;
      "H":     return 5'b00001;
      "D":     return 5'b10010;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic push(input string nm, input logic [4:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // one char per cycle: btn level driven before the edge, expected outputs after it
  task automatic seq(input string nm, input string lv, input string ev);
    for (int i = 0; i < lv.len(); i++) begin
      @(negedge clk);
      btn = (lv[i] == "1");
      push($sformatf("%s[%0d]", nm, i), dec(ev[i]));
    end
  endtask

  task automatic async_check(input string nm);
    push(nm, 5'b00000);
    async_chk = 1'b1;
    #1;
    async_chk = 1'b0;
  endtask

  // monitor: checks one queued expectation after each edge (or on an async probe)
  initial begin
    forever begin
      @(posedge clk or posedge async_chk);
      #1;
      if (exp_q.size() != 0) begin
        m_exp  = exp_q.pop_front();
        m_name = name_q.pop_front();
        m_act  = {press, rel, lp, dt, held};
        n_chk++;
        if (m_act !== m_exp) begin
          n_fail++;
          $display("FAIL %s: got %05b expected %05b (press,rel,long,dbl,held)", m_name, m_act, m_exp);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    #2;
    async_check("reset_state");
    @(negedge clk);
    rst = 1'b0;

    seq("short_tap",  "0111000000000",       ".P..R........");
    seq("long_hold",  "01111111111100",      ".P.......LHHR.");
    seq("rel_at_long","01111111100000000",   ".P.......R.......");
`ifdef BTN_DBL_TAP_EN
    seq("dbl_at_M6",  "0110000001100",       ".P.R.....D.R.");
`else
    seq("dbl_at_M6",  "0110000001100",       ".P.R.....P.R.");
`endif
    seq("rise_at_M7", "0110000000110000000", ".P.R......P.R......");
`ifdef BTN_DBL_TAP_EN
    seq("three_taps", "0100100100000000",    ".PR.DR.PR.......");
`else
    seq("three_taps", "0100100100000000",    ".PR.PR.PR.......");
`endif

    // reset while LONG_HELD with the button still down
    seq("held_pre_rst", "011111111111", ".P.......LHH");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    async_check("rst_in_held");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    btn = 1'b1;
    push("press_after_rst", dec("P"));
    seq("rst_release", "10000000", ".R......");

    repeat (3) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
